// File: rtl/rs_select_queue.sv
// rs_select_queue: reservation-station entry array with lowest-index
// allocation and lowest-index issue select. Entries track per-source
// readiness, wake up on writeback broadcasts, are allocated by dispatch
// and retired by the issue handshake.
module rs_select_queue #(
  parameter int ENTRY_NUM = 8,
  parameter int ENTRY_SEL = 3,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_disp_vld,
  output logic                 o_disp_rdy,
  input  logic [PAYLOAD_W-1:0] i_disp_payload,
  input  logic [TAG_W-1:0]     i_disp_tag1,
  input  logic [TAG_W-1:0]     i_disp_tag2,
  input  logic                 i_disp_rdy1,
  input  logic                 i_disp_rdy2,
  input  logic                 i_wb_vld,
  input  logic [TAG_W-1:0]     i_wb_tag,
  output logic                 o_issue_vld,
  input  logic                 i_issue_rdy,
  output logic [ENTRY_SEL-1:0] o_issue_idx,
  output logic [PAYLOAD_W-1:0] o_issue_payload,
  output logic [ENTRY_SEL:0]   o_busy_cnt
);

  localparam logic [ENTRY_SEL:0] CNT_ONE = (ENTRY_SEL+1)'(1);

  // Per-entry registered state
  logic [ENTRY_NUM-1:0] busy_q;
  logic [ENTRY_NUM-1:0] rdy1_q;
  logic [ENTRY_NUM-1:0] rdy2_q;
  logic [TAG_W-1:0]     tag1_q    [ENTRY_NUM];
  logic [TAG_W-1:0]     tag2_q    [ENTRY_NUM];
  logic [PAYLOAD_W-1:0] payload_q [ENTRY_NUM];
  logic [ENTRY_SEL:0]   busy_cnt_q;

  // Request vectors and their picks
  logic [ENTRY_NUM-1:0] free_vec;
  logic [ENTRY_NUM-1:0] cand_vec;
  logic [ENTRY_SEL-1:0] alloc_idx;
  logic [ENTRY_SEL-1:0] issue_idx;
  logic                 disp_fire;
  logic                 issue_fire;
  logic                 disp_rdy1;
  logic                 disp_rdy2;

  // Both vectors come purely from registered state, so there is no
  // combinational path from wakeup or issue into select or allocation.
  assign free_vec = ~busy_q;
  assign cand_vec = busy_q & rdy1_q & rdy2_q;

  assign o_disp_rdy      = |free_vec;
  assign o_issue_vld     = (|cand_vec) && !i_flush;
  assign o_issue_idx     = issue_idx;
  assign o_issue_payload = payload_q[issue_idx];
  assign o_busy_cnt      = busy_cnt_q;

  assign disp_fire  = i_disp_vld && o_disp_rdy && !i_flush;
  assign issue_fire = o_issue_vld && i_issue_rdy;

  // A source being broadcast in the dispatch cycle is captured as ready.
  assign disp_rdy1 = i_disp_rdy1 || (i_wb_vld && (i_wb_tag == i_disp_tag1));
  assign disp_rdy2 = i_disp_rdy2 || (i_wb_vld && (i_wb_tag == i_disp_tag2));

  // Lowest free index, scanned from the top so the lowest hit wins.
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = ENTRY_SEL'(i);
    end
  end

  // Lowest candidate index, same scan direction as allocation.
  always_comb begin
    issue_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (cand_vec[i]) issue_idx = ENTRY_SEL'(i);
    end
  end

  // Entry update: flush beats everything; otherwise dispatch writes a free
  // entry, issue retires the selected busy entry (dropping any wakeup to it),
  // and remaining busy entries pick up matching broadcasts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        tag1_q[i]    <= '0;
        tag2_q[i]    <= '0;
        payload_q[i] <= '0;
      end
    end else if (i_flush) begin
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (disp_fire && (alloc_idx == ENTRY_SEL'(i))) begin
          busy_q[i]    <= 1'b1;
          payload_q[i] <= i_disp_payload;
          tag1_q[i]    <= i_disp_tag1;
          tag2_q[i]    <= i_disp_tag2;
          rdy1_q[i]    <= disp_rdy1;
          rdy2_q[i]    <= disp_rdy2;
        end else if (issue_fire && (issue_idx == ENTRY_SEL'(i))) begin
          busy_q[i] <= 1'b0;
          rdy1_q[i] <= 1'b0;
          rdy2_q[i] <= 1'b0;
        end else if (busy_q[i] && i_wb_vld) begin
          if (tag1_q[i] == i_wb_tag) rdy1_q[i] <= 1'b1;
          if (tag2_q[i] == i_wb_tag) rdy2_q[i] <= 1'b1;
        end
      end
    end
  end

  // Occupancy counter tracking popcount(busy) incrementally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_cnt_q <= '0;
    end else if (i_flush) begin
      busy_cnt_q <= '0;
    end else begin
      case ({disp_fire, issue_fire})
        2'b10:   busy_cnt_q <= busy_cnt_q + CNT_ONE;
        2'b01:   busy_cnt_q <= busy_cnt_q - CNT_ONE;
        default: busy_cnt_q <= busy_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_select_queue.sv
// tb_rs_select_queue: directed self-checking bench for rs_select_queue.
module tb_rs_select_queue;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_disp_vld;
  logic        o_disp_rdy;
  logic [31:0] i_disp_payload;
  logic [5:0]  i_disp_tag1;
  logic [5:0]  i_disp_tag2;
  logic        i_disp_rdy1;
  logic        i_disp_rdy2;
  logic        i_wb_vld;
  logic [5:0]  i_wb_tag;
  logic        o_issue_vld;
  logic        i_issue_rdy;
  logic [2:0]  o_issue_idx;
  logic [31:0] o_issue_payload;
  logic [3:0]  o_busy_cnt;

  int checks = 0;
  int errors = 0;

  rs_select_queue #(
    .ENTRY_NUM(8), .ENTRY_SEL(3), .TAG_W(6), .PAYLOAD_W(32)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_disp_vld(i_disp_vld), .o_disp_rdy(o_disp_rdy),
    .i_disp_payload(i_disp_payload),
    .i_disp_tag1(i_disp_tag1), .i_disp_tag2(i_disp_tag2),
    .i_disp_rdy1(i_disp_rdy1), .i_disp_rdy2(i_disp_rdy2),
    .i_wb_vld(i_wb_vld), .i_wb_tag(i_wb_tag),
    .o_issue_vld(o_issue_vld), .i_issue_rdy(i_issue_rdy),
    .o_issue_idx(o_issue_idx), .o_issue_payload(o_issue_payload),
    .o_busy_cnt(o_busy_cnt)
  );

  // Free-running clock, 10 time-unit period
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 1'b0; i_disp_vld = 1'b0; i_disp_payload = '0;
    i_disp_tag1 = '0; i_disp_tag2 = '0; i_disp_rdy1 = 1'b0; i_disp_rdy2 = 1'b0;
    i_wb_vld = 1'b0; i_wb_tag = '0; i_issue_rdy = 1'b0;
  endtask

  task automatic set_disp(input logic [31:0] p, input logic [5:0] t1, input logic r1,
                          input logic [5:0] t2, input logic r2);
    i_disp_vld = 1'b1; i_disp_payload = p;
    i_disp_tag1 = t1; i_disp_rdy1 = r1; i_disp_tag2 = t2; i_disp_rdy2 = r2;
  endtask

  task automatic do_reset();
    idle();
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", o_busy_cnt); end
    checks++; if (o_disp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_disp_rdy got %b exp 1", o_disp_rdy); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue_vld got %b exp 0", o_issue_vld); end
    checks++; if (o_issue_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_issue_idx got %0d exp 0", o_issue_idx); end
    checks++; if (o_issue_payload !== 32'd0) begin errors++; $display("[TB] FAIL reset_payload got %h exp 0", o_issue_payload); end
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_disp(32'hA000 + 32'(i), 6'(i + 1), 1'b0, 6'(i + 1), 1'b0);
      tick();
    end
    idle();
    checks++; if (o_busy_cnt !== 4'd8) begin errors++; $display("[TB] FAIL fill_cnt got %0d exp 8", o_busy_cnt); end
    checks++; if (o_disp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL fill_disp_rdy got %b exp 0", o_disp_rdy); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL fill_issue_vld got %b exp 0", o_issue_vld); end
    set_disp(32'hDEAD, 6'd40, 1'b1, 6'd40, 1'b1);
    tick();
    idle();
    checks++; if (o_busy_cnt !== 4'd8) begin errors++; $display("[TB] FAIL ninth_disp_cnt got %0d exp 8", o_busy_cnt); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL ninth_disp_vld got %b exp 0", o_issue_vld); end
  endtask

  task automatic test_wakeup();
    i_wb_vld = 1'b1; i_wb_tag = 6'd5;
    #1;
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL wake_same_cycle got %b exp 0", o_issue_vld); end
    tick();
    idle();
    checks++; if (o_issue_vld !== 1'b1) begin errors++; $display("[TB] FAIL wake_vld got %b exp 1", o_issue_vld); end
    checks++; if (o_issue_idx !== 3'd4) begin errors++; $display("[TB] FAIL wake_idx got %0d exp 4", o_issue_idx); end
    checks++; if (o_issue_payload !== 32'hA004) begin errors++; $display("[TB] FAIL wake_payload got %h exp A004", o_issue_payload); end
    // Handshake while full: the concurrent dispatch must be ignored
    i_issue_rdy = 1'b1;
    set_disp(32'hC0DE, 6'd50, 1'b1, 6'd50, 1'b1);
    tick();
    idle();
    checks++; if (o_busy_cnt !== 4'd7) begin errors++; $display("[TB] FAIL full_issue_cnt got %0d exp 7", o_busy_cnt); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL full_issue_vld got %b exp 0", o_issue_vld); end
    checks++; if (o_disp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL full_issue_disp_rdy got %b exp 1", o_disp_rdy); end
    set_disp(32'hB000, 6'd20, 1'b1, 6'd20, 1'b1);
    tick();
    idle();
    checks++; if (o_issue_idx !== 3'd4) begin errors++; $display("[TB] FAIL realloc_idx got %0d exp 4", o_issue_idx); end
    checks++; if (o_issue_payload !== 32'hB000) begin errors++; $display("[TB] FAIL realloc_payload got %h exp B000", o_issue_payload); end
    checks++; if (o_busy_cnt !== 4'd8) begin errors++; $display("[TB] FAIL realloc_cnt got %0d exp 8", o_busy_cnt); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_disp(32'hD000, 6'd9, 1'b0, 6'd3, 1'b1);
    i_wb_vld = 1'b1; i_wb_tag = 6'd9;
    #1;
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL bypass_pre_vld got %b exp 0", o_issue_vld); end
    tick();
    idle();
    checks++; if (o_issue_vld !== 1'b1) begin errors++; $display("[TB] FAIL bypass_vld got %b exp 1", o_issue_vld); end
    checks++; if (o_issue_idx !== 3'd0) begin errors++; $display("[TB] FAIL bypass_idx got %0d exp 0", o_issue_idx); end
    checks++; if (o_issue_payload !== 32'hD000) begin errors++; $display("[TB] FAIL bypass_payload got %h exp D000", o_issue_payload); end
    // Non-matching broadcast must not mark the source ready
    set_disp(32'hD001, 6'd10, 1'b0, 6'd3, 1'b1);
    i_wb_vld = 1'b1; i_wb_tag = 6'd11;
    tick();
    idle();
    i_issue_rdy = 1'b1;
    tick();
    idle();
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL nobypass_vld got %b exp 0", o_issue_vld); end
    checks++; if (o_busy_cnt !== 4'd1) begin errors++; $display("[TB] FAIL nobypass_cnt got %0d exp 1", o_busy_cnt); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_disp(32'hE000 + 32'(i), 6'(30 + i), (i == 2 || i == 6), 6'(30 + i), (i == 2 || i == 6));
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_issue_idx !== 3'd2 || o_issue_vld !== 1'b1) begin errors++; $display("[TB] FAIL hold_idx cycle %0d got vld %b idx %0d exp 1/2", k, o_issue_vld, o_issue_idx); end
      tick();
    end
    i_issue_rdy = 1'b1;
    tick();
    checks++; if (o_busy_cnt !== 4'd7) begin errors++; $display("[TB] FAIL hold_cnt1 got %0d exp 7", o_busy_cnt); end
    checks++; if (o_issue_idx !== 3'd6) begin errors++; $display("[TB] FAIL hold_idx2 got %0d exp 6", o_issue_idx); end
    tick();
    checks++; if (o_busy_cnt !== 4'd6) begin errors++; $display("[TB] FAIL hold_cnt2 got %0d exp 6", o_busy_cnt); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL hold_empty_vld got %b exp 0", o_issue_vld); end
    idle();
    // A newly woken lower index replaces the presented one
    i_wb_vld = 1'b1; i_wb_tag = 6'd37;
    tick();
    idle();
    checks++; if (o_issue_idx !== 3'd7) begin errors++; $display("[TB] FAIL replace_idx7 got %0d exp 7", o_issue_idx); end
    i_wb_vld = 1'b1; i_wb_tag = 6'd31;
    tick();
    idle();
    checks++; if (o_issue_idx !== 3'd1) begin errors++; $display("[TB] FAIL replace_idx1 got %0d exp 1", o_issue_idx); end
    checks++; if (o_issue_payload !== 32'hE001) begin errors++; $display("[TB] FAIL replace_payload got %h exp E001", o_issue_payload); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_disp(32'hF000, 6'd1, 1'b1, 6'd1, 1'b1); tick();
    set_disp(32'hF001, 6'd2, 1'b0, 6'd2, 1'b0); tick();
    set_disp(32'hF002, 6'd3, 1'b0, 6'd3, 1'b0); tick();
    idle();
    checks++; if (o_busy_cnt !== 4'd3) begin errors++; $display("[TB] FAIL b2b_pre_cnt got %0d exp 3", o_busy_cnt); end
    set_disp(32'hF003, 6'd4, 1'b1, 6'd4, 1'b1);
    i_issue_rdy = 1'b1;
    tick();
    idle();
    checks++; if (o_busy_cnt !== 4'd3) begin errors++; $display("[TB] FAIL b2b_cnt got %0d exp 3", o_busy_cnt); end
    checks++; if (o_issue_idx !== 3'd3) begin errors++; $display("[TB] FAIL b2b_idx got %0d exp 3", o_issue_idx); end
    checks++; if (o_issue_payload !== 32'hF003) begin errors++; $display("[TB] FAIL b2b_payload got %h exp F003", o_issue_payload); end
  endtask

  task automatic test_flush();
    do_reset();
    set_disp(32'h1111, 6'd1, 1'b1, 6'd1, 1'b1); tick();
    set_disp(32'h2222, 6'd2, 1'b1, 6'd2, 1'b1); tick();
    idle();
    i_flush = 1'b1;
    set_disp(32'h3333, 6'd5, 1'b1, 6'd5, 1'b1);
    i_issue_rdy = 1'b1; i_wb_vld = 1'b1; i_wb_tag = 6'd2;
    #1;
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL flush_comb_vld got %b exp 0", o_issue_vld); end
    tick();
    idle();
    checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("[TB] FAIL flush_cnt got %0d exp 0", o_busy_cnt); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL flush_vld got %b exp 0", o_issue_vld); end
    checks++; if (o_disp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL flush_disp_rdy got %b exp 1", o_disp_rdy); end
    tick();
    checks++; if (o_issue_vld !== 1'b0 || o_busy_cnt !== 4'd0) begin errors++; $display("[TB] FAIL flush_nowrite got vld %b cnt %0d exp 0/0", o_issue_vld, o_busy_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_disp(32'h5000 + 32'(i), 6'(i + 1), (i == 0), 6'(i + 1), (i == 0));
      tick();
    end
    idle();
    checks++; if (o_busy_cnt !== 4'd5 || o_issue_vld !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre got cnt %0d vld %b exp 5/1", o_busy_cnt, o_issue_vld); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("[TB] FAIL arst_cnt got %0d exp 0", o_busy_cnt); end
    checks++; if (o_issue_vld !== 1'b0) begin errors++; $display("[TB] FAIL arst_vld got %b exp 0", o_issue_vld); end
    checks++; if (o_disp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL arst_disp_rdy got %b exp 1", o_disp_rdy); end
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_busy_cnt !== 4'd0) begin errors++; $display("[TB] FAIL arst_post_cnt got %0d exp 0", o_busy_cnt); end
  endtask

  // Run all scenarios in order and report
  initial begin
    test_reset();
    test_fill();
    test_wakeup();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
